// File: rtl/e1_frame_align_mon.sv
// E1 frame / multiframe alignment monitor: hunts for the FAS at any bit offset,
// confirms alignment with loss/regain thresholds, then tracks the MFAS.
module e1_frame_align_mon #(
  parameter int unsigned         WORD_W     = 8,
  parameter int unsigned         FRAME_BITS = 256,
  parameter logic [WORD_W-1:0]   FAS_WORD   = 8'h1B,
  parameter logic [WORD_W-1:0]   FAS_MASK   = 8'h7F,
  parameter int unsigned         LOSS_N     = 3,
  parameter int unsigned         REGAIN_N   = 3,
  parameter int unsigned         MF_SLOT    = 16,
  parameter logic [WORD_W-1:0]   MFAS_WORD  = 8'h0B,
  parameter logic [WORD_W-1:0]   MFAS_MASK  = 8'hFF,
  parameter int unsigned         MF_FRAMES  = 16,
  parameter int unsigned         MF_LOSS_N  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            bit_en,
  input  logic                            din,
  output logic                            frame_sync,
  output logic                            mf_sync,
  output logic                            frame_start,
  output logic                            mf_start,
  output logic                            los_evt,
  output logic [$clog2(FRAME_BITS)-1:0]   bit_pos,
  output logic [$clog2(MF_FRAMES)-1:0]    frame_num
);

  localparam int unsigned PW     = $clog2(FRAME_BITS);
  localparam int unsigned FW     = $clog2(MF_FRAMES);
  localparam int unsigned HW     = $clog2(REGAIN_N + 1);
  localparam int unsigned LW     = $clog2(LOSS_N + 1);
  localparam int unsigned MW     = $clog2(MF_LOSS_N + 1);
  localparam int unsigned MF_CHK = MF_SLOT * WORD_W + WORD_W - 1;

  typedef enum logic [1:0] {HUNT, REGAIN, SYNC} fstate_t;
  typedef enum logic       {MF_HUNT, MF_SYNC}    mstate_t;

  fstate_t fstate;
  mstate_t mstate;

  // Only the older WORD_W-1 bits are stored; the current din completes the word.
  logic [WORD_W-2:0] sr;
  logic [WORD_W-1:0] word;
  logic [HW-1:0]     hit_cnt;
  logic [LW-1:0]     miss_cnt;
  logic [MW-1:0]     mmiss;

  logic [PW-1:0] idx, pos_n;
  logic [FW-1:0] fn_inc, fn_n;
  logic          hit, mhit, fas_pt, mf_pt, wrap;
  logic          f_gain, f_lose, fsync_n, fstart_n;
  logic          mf_run, mf_hit_go, mf_drop, mf_stay, msync_n;

  assign word   = {sr, din};
  assign hit    = ((word ^ FAS_WORD) & FAS_MASK) == '0;
  assign mhit   = ((word ^ MFAS_WORD) & MFAS_MASK) == '0;
  assign idx    = (bit_pos == PW'(FRAME_BITS - 1)) ? '0 : bit_pos + PW'(1);
  assign pos_n  = (fstate == HUNT && hit) ? PW'(WORD_W - 1) : idx;
  assign fas_pt = idx == PW'(WORD_W - 1);
  assign mf_pt  = idx == PW'(MF_CHK);
  assign wrap   = pos_n == PW'(FRAME_BITS - 1);

  // Frame alignment decisions for the current bit
  assign f_gain   = (fstate == REGAIN && fas_pt && hit && hit_cnt == HW'(REGAIN_N - 1)) ||
                    (fstate == HUNT && hit && REGAIN_N == 1);
  assign f_lose   = fstate == SYNC && fas_pt && !hit && miss_cnt == LW'(LOSS_N - 1);
  assign fsync_n  = (fstate == SYNC && !f_lose) || f_gain;
  assign fstart_n = wrap && fsync_n;

  // Multiframe decisions; only live while frame alignment is held
  assign mf_run    = fstate == SYNC && !f_lose;
  assign mf_hit_go = mstate == MF_HUNT && mf_pt && mhit;
  assign mf_drop   = mstate == MF_SYNC && mf_pt && frame_num == '0 && !mhit &&
                     mmiss == MW'(MF_LOSS_N - 1);
  assign mf_stay   = (mstate == MF_SYNC && !mf_drop) || mf_hit_go;
  assign msync_n   = mf_run && mf_stay;
  assign fn_inc    = (frame_num == FW'(MF_FRAMES - 1)) ? '0 : frame_num + FW'(1);
  assign fn_n      = !msync_n ? '0 : (wrap ? fn_inc : frame_num);

  always_ff @(posedge clk) begin
    if (rst) begin
      fstate      <= HUNT;
      mstate      <= MF_HUNT;
      sr          <= '0;
      bit_pos     <= '0;
      frame_num   <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      mmiss       <= '0;
      frame_sync  <= 1'b0;
      mf_sync     <= 1'b0;
      frame_start <= 1'b0;
      mf_start    <= 1'b0;
      los_evt     <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      mf_start    <= 1'b0;
      los_evt     <= 1'b0;
      if (bit_en) begin
        sr          <= word[WORD_W-2:0];
        bit_pos     <= pos_n;
        frame_start <= fstart_n;
        mf_start    <= fstart_n && msync_n && fn_n == '0;
        frame_num   <= fn_n;
        mf_sync     <= msync_n;

        unique case (fstate)
          HUNT: begin
            if (hit) begin
              hit_cnt <= HW'(1);
              if (f_gain) begin
                fstate     <= SYNC;
                frame_sync <= 1'b1;
              end else begin
                fstate <= REGAIN;
              end
            end
          end
          REGAIN: begin
            if (fas_pt) begin
              if (hit) begin
                hit_cnt <= hit_cnt + HW'(1);
                if (f_gain) begin
                  fstate     <= SYNC;
                  frame_sync <= 1'b1;
                  miss_cnt   <= '0;
                end
              end else begin
                fstate <= HUNT;
              end
            end
          end
          SYNC: begin
            if (fas_pt) begin
              if (hit) begin
                miss_cnt <= '0;
              end else if (f_lose) begin
                fstate     <= HUNT;
                frame_sync <= 1'b0;
                los_evt    <= 1'b1;
                miss_cnt   <= '0;
              end else begin
                miss_cnt <= miss_cnt + LW'(1);
              end
            end
          end
          default: fstate <= HUNT;
        endcase

        if (!mf_run) begin
          mstate <= MF_HUNT;
          mmiss  <= '0;
        end else if (mf_hit_go) begin
          mstate <= MF_SYNC;
          mmiss  <= '0;
        end else if (mstate == MF_SYNC && mf_pt && frame_num == '0) begin
          if (mhit) begin
            mmiss <= '0;
          end else if (mf_drop) begin
            mstate <= MF_HUNT;
            mmiss  <= '0;
          end else begin
            mmiss <= mmiss + MW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_e1_frame_align_mon.sv
// Directed bench for e1_frame_align_mon: acquisition, loss, offset start,
// false FAS rejection, multiframe tracking and mid-frame reset.
module tb_e1_frame_align_mon;

  logic       clk = 1'b0;
  logic       rst, bit_en, din;
  logic       frame_sync, mf_sync, frame_start, mf_start, los_evt;
  logic [7:0] bit_pos;
  logic [3:0] frame_num;

  int   errors = 0;
  int   checks = 0;
  int   fs_cnt, mf_cnt, los_cnt;
  logic fs_seen;
  logic [7:0] frm [32];

  always #5 clk = ~clk;

  e1_frame_align_mon #(
    .WORD_W(8), .FRAME_BITS(256), .FAS_WORD(8'h1B), .FAS_MASK(8'h7F),
    .LOSS_N(3), .REGAIN_N(3), .MF_SLOT(16), .MFAS_WORD(8'h0B),
    .MFAS_MASK(8'hFF), .MF_FRAMES(16), .MF_LOSS_N(2)
  ) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .din(din),
    .frame_sync(frame_sync), .mf_sync(mf_sync), .frame_start(frame_start),
    .mf_start(mf_start), .los_evt(los_evt), .bit_pos(bit_pos), .frame_num(frame_num)
  );

  // One accepted bit per call; outputs sampled 1 ns after the edge
  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_en = 1'b1;
    din    = b;
    @(posedge clk);
    #1;
    if (frame_start) fs_cnt++;
    if (mf_start)    mf_cnt++;
    if (los_evt)     los_cnt++;
    if (frame_sync)  fs_seen = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_slots(input int a, input int b);
    for (int s = a; s <= b; s++) send_byte(frm[s]);
  endtask

  task automatic fill(input logic [7:0] ts0, input logic [7:0] ts16);
    for (int s = 0; s < 32; s++) frm[s] = 8'h55;
    frm[0]  = ts0;
    frm[16] = ts16;
  endtask

  task automatic send_frames(input int n, input logic [7:0] ts16);
    fill(8'h1B, ts16);
    for (int f = 0; f < n; f++) send_slots(0, 31);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_en = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bit_en = 1'b0; din = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    fs_cnt = 0; mf_cnt = 0; los_cnt = 0; fs_seen = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (frame_sync !== 1'b0 || mf_sync !== 1'b0) begin errors++; $display("FAIL rst_sync: frame_sync=%b mf_sync=%b want 0 0", frame_sync, mf_sync); end
    checks++; if (frame_start !== 1'b0 || mf_start !== 1'b0 || los_evt !== 1'b0) begin errors++; $display("FAIL rst_pulses: fs=%b ms=%b los=%b want 0", frame_start, mf_start, los_evt); end
    checks++; if (bit_pos !== 8'd0 || frame_num !== 4'd0) begin errors++; $display("FAIL rst_pos: bit_pos=%0d frame_num=%0d want 0 0", bit_pos, frame_num); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_acquire();
    do_reset();
    fill(8'h1B, 8'h55);
    send_byte(8'h1B);
    checks++; if (bit_pos !== 8'd7) begin errors++; $display("FAIL acq_hunt_pos: bit_pos=%0d want 7", bit_pos); end
    checks++; if (frame_sync !== 1'b0) begin errors++; $display("FAIL acq_early: frame_sync=%b want 0", frame_sync); end
    send_slots(1, 31);
    send_slots(0, 31);
    for (int i = 7; i >= 1; i--) send_bit(frm[0][i]);
    checks++; if (frame_sync !== 1'b0) begin errors++; $display("FAIL acq_pre_sync: frame_sync=%b want 0", frame_sync); end
    send_bit(frm[0][0]);
    checks++; if (frame_sync !== 1'b1) begin errors++; $display("FAIL acq_sync: frame_sync=%b want 1", frame_sync); end
    send_slots(1, 31);
    checks++; if (frame_start !== 1'b1 || bit_pos !== 8'd255) begin errors++; $display("FAIL acq_fstart: frame_start=%b bit_pos=%0d want 1 255", frame_start, bit_pos); end
    send_byte(8'h1B);
    idle(3);
    checks++; if (bit_pos !== 8'd7 || frame_start !== 1'b0 || frame_sync !== 1'b1) begin errors++; $display("FAIL acq_idle: bit_pos=%0d fs=%b sync=%b want 7 0 1", bit_pos, frame_start, frame_sync); end
    send_slots(1, 31);
    checks++; if (fs_cnt !== 2 || frame_start !== 1'b1) begin errors++; $display("FAIL acq_fcount: fs_cnt=%0d frame_start=%b want 2 1", fs_cnt, frame_start); end
  endtask

  task automatic test_loss();
    fs_cnt = 0; los_cnt = 0;
    fill(8'h55, 8'h55); send_slots(0, 31); send_slots(0, 31);
    checks++; if (frame_sync !== 1'b1 || los_cnt !== 0) begin errors++; $display("FAIL loss_two_miss: sync=%b los_cnt=%0d want 1 0", frame_sync, los_cnt); end
    fill(8'h1B, 8'h55); send_slots(0, 31);
    fill(8'h55, 8'h55); send_slots(0, 31); send_slots(0, 31);
    checks++; if (frame_sync !== 1'b1 || los_cnt !== 0) begin errors++; $display("FAIL loss_restore: sync=%b los_cnt=%0d want 1 0", frame_sync, los_cnt); end
    for (int i = 7; i >= 1; i--) send_bit(frm[0][i]);
    checks++; if (frame_sync !== 1'b1 || los_evt !== 1'b0) begin errors++; $display("FAIL loss_pre: sync=%b los=%b want 1 0", frame_sync, los_evt); end
    send_bit(frm[0][0]);
    checks++; if (frame_sync !== 1'b0 || los_evt !== 1'b1) begin errors++; $display("FAIL loss_third: sync=%b los=%b want 0 1", frame_sync, los_evt); end
    send_slots(1, 31);
    checks++; if (los_cnt !== 1 || fs_cnt !== 5 || frame_start !== 1'b0) begin errors++; $display("FAIL loss_after: los_cnt=%0d fs_cnt=%0d fs=%b want 1 5 0", los_cnt, fs_cnt, frame_start); end
  endtask

  task automatic test_offset();
    do_reset();
    for (int i = 0; i < 37; i++) send_bit(1'(i % 2));
    fill(8'h1B, 8'h55);
    send_byte(8'h1B);
    checks++; if (bit_pos !== 8'd7 || frame_sync !== 1'b0) begin errors++; $display("FAIL off_hunt: bit_pos=%0d sync=%b want 7 0", bit_pos, frame_sync); end
    send_slots(1, 31);
    send_slots(0, 31);
    for (int i = 7; i >= 1; i--) send_bit(frm[0][i]);
    checks++; if (frame_sync !== 1'b0) begin errors++; $display("FAIL off_pre: frame_sync=%b want 0", frame_sync); end
    send_bit(frm[0][0]);
    checks++; if (frame_sync !== 1'b1 || bit_pos !== 8'd7) begin errors++; $display("FAIL off_sync: sync=%b bit_pos=%0d want 1 7", frame_sync, bit_pos); end
    send_slots(1, 31);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL off_fstart: frame_start=%b want 1", frame_start); end
  endtask

  task automatic test_false_fas();
    do_reset();
    fill(8'h55, 8'h55);
    frm[5] = 8'h1B;
    send_slots(0, 5);
    checks++; if (bit_pos !== 8'd7 || frame_sync !== 1'b0) begin errors++; $display("FAIL ff_hit: bit_pos=%0d sync=%b want 7 0", bit_pos, frame_sync); end
    send_slots(6, 31);
    fill(8'h1B, 8'h55);
    send_slots(0, 31);
    send_byte(8'h1B);
    checks++; if (bit_pos !== 8'd7) begin errors++; $display("FAIL ff_rehunt: bit_pos=%0d want 7", bit_pos); end
    send_slots(1, 31);
    send_slots(0, 31);
    checks++; if (fs_seen !== 1'b0) begin errors++; $display("FAIL ff_glitch: frame_sync seen=%b want 0", fs_seen); end
    send_byte(8'h1B);
    checks++; if (frame_sync !== 1'b1) begin errors++; $display("FAIL ff_sync: frame_sync=%b want 1", frame_sync); end
    send_slots(1, 31);
  endtask

  task automatic test_multiframe();
    do_reset();
    send_frames(3, 8'h55);
    fill(8'h1B, 8'h0B);
    send_slots(0, 16);
    checks++; if (mf_sync !== 1'b1 || frame_num !== 4'd0 || bit_pos !== 8'd135) begin errors++; $display("FAIL mf_acq: mf_sync=%b frame_num=%0d bit_pos=%0d want 1 0 135", mf_sync, frame_num, bit_pos); end
    send_slots(17, 31);
    checks++; if (frame_start !== 1'b1 || mf_start !== 1'b0 || frame_num !== 4'd1) begin errors++; $display("FAIL mf_first_wrap: fs=%b ms=%b frame_num=%0d want 1 0 1", frame_start, mf_start, frame_num); end
    for (int k = 2; k <= 16; k++) begin
      send_frames(1, 8'h55);
      checks++; if (frame_num !== 4'(k % 16) || mf_start !== (k == 16)) begin errors++; $display("FAIL mf_count: k=%0d frame_num=%0d mf_start=%b", k, frame_num, mf_start); end
    end
    checks++; if (mf_cnt !== 1) begin errors++; $display("FAIL mf_cnt1: mf_cnt=%0d want 1", mf_cnt); end
    send_frames(1, 8'h0B);
    send_frames(15, 8'h55);
    checks++; if (mf_cnt !== 2 || mf_sync !== 1'b1) begin errors++; $display("FAIL mf_cnt2: mf_cnt=%0d mf_sync=%b want 2 1", mf_cnt, mf_sync); end
    fill(8'h1B, 8'h55);
    send_slots(0, 16);
    checks++; if (mf_sync !== 1'b1) begin errors++; $display("FAIL mf_one_miss: mf_sync=%b want 1", mf_sync); end
    send_slots(17, 31);
    send_frames(15, 8'h55);
    checks++; if (mf_cnt !== 3) begin errors++; $display("FAIL mf_cnt3: mf_cnt=%0d want 3", mf_cnt); end
    fill(8'h1B, 8'h55);
    send_slots(0, 16);
    checks++; if (mf_sync !== 1'b0 || frame_num !== 4'd0) begin errors++; $display("FAIL mf_drop: mf_sync=%b frame_num=%0d want 0 0", mf_sync, frame_num); end
    send_slots(17, 31);
    checks++; if (frame_num !== 4'd0 || mf_start !== 1'b0 || frame_sync !== 1'b1) begin errors++; $display("FAIL mf_after_drop: frame_num=%0d ms=%b sync=%b want 0 0 1", frame_num, mf_start, frame_sync); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_frames(3, 8'h55);
    send_frames(1, 8'h0B);
    checks++; if (mf_sync !== 1'b1 || frame_sync !== 1'b1 || frame_num !== 4'd1) begin errors++; $display("FAIL rm_pre: mf=%b sync=%b frame_num=%0d want 1 1 1", mf_sync, frame_sync, frame_num); end
    fill(8'h1B, 8'h55);
    send_slots(0, 9);
    @(negedge clk);
    rst = 1'b1; bit_en = 1'b1; din = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (frame_sync !== 1'b0 || mf_sync !== 1'b0 || bit_pos !== 8'd0 || frame_num !== 4'd0) begin errors++; $display("FAIL rm_state: sync=%b mf=%b bit_pos=%0d frame_num=%0d want 0 0 0 0", frame_sync, mf_sync, bit_pos, frame_num); end
    checks++; if (frame_start !== 1'b0 || mf_start !== 1'b0 || los_evt !== 1'b0) begin errors++; $display("FAIL rm_pulses: fs=%b ms=%b los=%b want 0", frame_start, mf_start, los_evt); end
    @(negedge clk);
    rst = 1'b0; bit_en = 1'b0;
    send_byte(8'h1B);
    checks++; if (bit_pos !== 8'd7 || frame_sync !== 1'b0) begin errors++; $display("FAIL rm_hunt: bit_pos=%0d sync=%b want 7 0", bit_pos, frame_sync); end
    send_slots(1, 31);
    send_slots(0, 31);
    send_byte(8'h1B);
    checks++; if (frame_sync !== 1'b1) begin errors++; $display("FAIL rm_resync: frame_sync=%b want 1", frame_sync); end
  endtask

  initial begin
    rst = 1'b1; bit_en = 1'b0; din = 1'b0;
    fs_cnt = 0; mf_cnt = 0; los_cnt = 0; fs_seen = 1'b0;
    test_reset();
    test_acquire();
    test_loss();
    test_offset();
    test_false_fas();
    test_multiframe();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
